// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and the RV32I datapath.
// The master side is the controller; the slave side is the datapath and memory port.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       br_cond;
  logic       mem_ready;

  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_sel;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_sel;
  logic       alu_a_sel;
  logic       alu_b_sel;
  logic [1:0] alu_op;
  logic       rf_we;
  logic [1:0] wb_sel;
  logic       instr_retired;
  logic       illegal;
  logic       bus_err;
  logic [2:0] state;

  modport master (
    input  opcode, funct3, br_cond, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
           alu_op, rf_we, wb_sel, instr_retired, illegal, bus_err, state
  );

  modport slave (
    output opcode, funct3, br_cond, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
           alu_op, rf_we, wb_sel, instr_retired, illegal, bus_err, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Control FSM sequencing the RV32I multicycle datapath through fetch/decode/execute/mem/wb,
// with sticky traps for illegal opcodes and memory handshake timeouts.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input logic               clk,
  input logic               rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMem       = 3'd3,
    StWriteback = 3'd4,
    StTrap      = 3'd7
  } state_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
  localparam bit               TimeoutEn  = (TIMEOUT != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;

  logic is_r, is_imm, is_load, is_store, is_branch, is_lui, is_auipc, is_jal, is_jalr, is_legal;
  logic waiting, timed_out;
  logic       alu_a, alu_b;
  logic [1:0] alu_op_dec;

  assign is_r      = (bus.opcode == OpR);
  assign is_imm    = (bus.opcode == OpImm);
  assign is_load   = (bus.opcode == OpLoad);
  assign is_store  = (bus.opcode == OpStore);
  assign is_branch = (bus.opcode == OpBranch);
  assign is_lui    = (bus.opcode == OpLui);
  assign is_auipc  = (bus.opcode == OpAuipc);
  assign is_jal    = (bus.opcode == OpJal);
  assign is_jalr   = (bus.opcode == OpJalr);
  assign is_legal  = is_r | is_imm | is_load | is_store | is_branch | is_lui | is_auipc |
                     is_jal | is_jalr;

  assign alu_a      = is_auipc | is_jal;
  assign alu_b      = ~is_r;
  assign alu_op_dec = is_r ? 2'd1 : (is_imm ? 2'd2 : 2'd0);

  // A completing handshake on the limit cycle takes priority over the timeout.
  assign waiting   = ((state_q == StFetch) || (state_q == StMem)) && !bus.mem_ready;
  assign timed_out = TimeoutEn && waiting && (cnt_q == TimeoutCnt);

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    unique case (state_q)
      StFetch: begin
        if (bus.mem_ready) begin
          state_d = StDecode;
        end else if (timed_out) begin
          state_d   = StTrap;
          bus_err_d = 1'b1;
        end
      end
      StDecode: begin
        if (is_legal) begin
          state_d = StExecute;
        end else begin
          state_d   = StTrap;
          illegal_d = 1'b1;
        end
      end
      StExecute: begin
        if (is_branch)                state_d = StFetch;
        else if (is_load || is_store) state_d = StMem;
        else                          state_d = StWriteback;
      end
      StMem: begin
        if (bus.mem_ready) begin
          state_d = is_load ? StWriteback : StFetch;
        end else if (timed_out) begin
          state_d   = StTrap;
          bus_err_d = 1'b1;
        end
      end
      StWriteback: state_d = StFetch;
      StTrap:      state_d = StTrap;
      default:     state_d = StTrap;
    endcase

    if (state_d != state_q)         cnt_d = '0;
    else if (waiting && TimeoutEn)  cnt_d = cnt_q + CNT_W'(1);
    else                            cnt_d = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_addr_sel  = 1'b0;
    bus.ir_we         = 1'b0;
    bus.pc_we         = 1'b0;
    bus.pc_sel        = 2'd0;
    bus.alu_a_sel     = 1'b0;
    bus.alu_b_sel     = 1'b0;
    bus.alu_op        = 2'd0;
    bus.rf_we         = 1'b0;
    bus.wb_sel        = 2'd0;
    bus.instr_retired = 1'b0;
    unique case (state_q)
      StFetch: begin
        // Request is suppressed while reset is held so nothing is issued to memory.
        bus.mem_req = rst_n;
        bus.ir_we   = bus.mem_ready;
      end
      StExecute: begin
        bus.alu_a_sel = alu_a;
        bus.alu_b_sel = alu_b;
        bus.alu_op    = alu_op_dec;
        if (is_branch) begin
          bus.pc_we         = 1'b1;
          bus.pc_sel        = bus.br_cond ? 2'd2 : 2'd0;
          bus.instr_retired = 1'b1;
        end
      end
      StMem: begin
        bus.mem_req      = 1'b1;
        bus.mem_addr_sel = 1'b1;
        bus.mem_we       = is_store;
        bus.alu_a_sel    = alu_a;
        bus.alu_b_sel    = alu_b;
        bus.alu_op       = alu_op_dec;
        if (bus.mem_ready && is_store) begin
          bus.pc_we         = 1'b1;
          bus.instr_retired = 1'b1;
        end
      end
      StWriteback: begin
        bus.rf_we         = 1'b1;
        bus.pc_we         = 1'b1;
        bus.instr_retired = 1'b1;
        bus.alu_a_sel     = alu_a;
        bus.alu_b_sel     = alu_b;
        bus.alu_op        = alu_op_dec;
        if (is_load)                bus.wb_sel = 2'd1;
        else if (is_jal || is_jalr) bus.wb_sel = 2'd2;
        else if (is_lui)            bus.wb_sel = 2'd3;
        if (is_jal)       bus.pc_sel = 2'd2;
        else if (is_jalr) bus.pc_sel = 2'd1;
      end
      default: ;
    endcase
  end

  assign bus.illegal = illegal_q;
  assign bus.bus_err = bus_err_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: builds per-cycle expected outputs from instruction-level rules
// and compares every cycle; instruction latencies are pinned with literal values.
module tb_multicycle_ctrl;
  localparam int unsigned Timeout = 4;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [1:0] alu_op;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       instr_retired;
    logic       illegal;
    logic       bus_err;
  } out_t;

  typedef struct {
    logic       rst_n;
    logic       mem_ready;
    logic       br_cond;
    logic [6:0] opcode;
    out_t       o;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(
    .TIMEOUT(Timeout),
    .CNT_W  (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  cyc_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   m_ill = 1'b0;
  bit   m_be  = 1'b0;

  function automatic cyc_t blank(input logic [6:0] op, input logic br);
    cyc_t c;
    c.rst_n     = 1'b1;
    c.mem_ready = 1'b0;
    c.br_cond   = br;
    c.opcode    = op;
    c.o         = '0;
    return c;
  endfunction

  function automatic void push(input cyc_t c);
    cyc_t t;
    t           = c;
    t.o.illegal = m_ill;
    t.o.bus_err = m_be;
    q.push_back(t);
  endfunction

  // Expected cycle sequence for one instruction from its class and the memory wait pattern.
  task automatic gen_instr(input logic [6:0] op, input logic br, input int fwait,
                           input int mwait, input bit cut);
    cyc_t c;
    logic a, b;
    logic [1:0] aop;
    bit legal;
    legal = op inside {OpR, OpImm, OpLoad, OpStore, OpBranch, OpLui, OpAuipc, OpJal, OpJalr};
    a   = (op == OpAuipc) || (op == OpJal);
    b   = (op != OpR);
    aop = (op == OpR) ? 2'd1 : ((op == OpImm) ? 2'd2 : 2'd0);
    for (int i = 0; i < fwait; i++) begin
      c = blank(op, br); c.o.state = 3'd0; c.o.mem_req = 1'b1; push(c);
    end
    c = blank(op, br); c.mem_ready = 1'b1;
    c.o.state = 3'd0; c.o.mem_req = 1'b1; c.o.ir_we = 1'b1; push(c);
    c = blank(op, br); c.o.state = 3'd1; push(c);
    if (!legal) begin
      m_ill = 1'b1;
      return;
    end
    c = blank(op, br); c.o.state = 3'd2;
    c.o.alu_a_sel = a; c.o.alu_b_sel = b; c.o.alu_op = aop;
    if (op == OpBranch) begin
      c.o.pc_we = 1'b1; c.o.pc_sel = br ? 2'd2 : 2'd0; c.o.instr_retired = 1'b1;
      push(c);
      return;
    end
    push(c);
    if (op == OpLoad || op == OpStore) begin
      for (int i = 0; i <= mwait; i++) begin
        if (i == mwait && cut) return;
        c = blank(op, br); c.o.state = 3'd3;
        c.o.mem_req = 1'b1; c.o.mem_addr_sel = 1'b1; c.o.mem_we = (op == OpStore);
        c.o.alu_a_sel = a; c.o.alu_b_sel = b; c.o.alu_op = aop;
        if (i == mwait) begin
          c.mem_ready = 1'b1;
          if (op == OpStore) begin
            c.o.pc_we = 1'b1; c.o.instr_retired = 1'b1;
          end
        end
        push(c);
      end
      if (op == OpStore) return;
    end
    c = blank(op, br); c.o.state = 3'd4;
    c.o.rf_we = 1'b1; c.o.pc_we = 1'b1; c.o.instr_retired = 1'b1;
    c.o.alu_a_sel = a; c.o.alu_b_sel = b; c.o.alu_op = aop;
    c.o.wb_sel = (op == OpLoad) ? 2'd1 : (op == OpJal || op == OpJalr) ? 2'd2 :
                 (op == OpLui) ? 2'd3 : 2'd0;
    c.o.pc_sel = (op == OpJal) ? 2'd2 : (op == OpJalr) ? 2'd1 : 2'd0;
    push(c);
  endtask

  task automatic gen_trap(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank(7'h00, 1'b0); c.mem_ready = i[0]; c.o.state = 3'd7; push(c);
    end
  endtask

  task automatic gen_reset(input int n);
    cyc_t c;
    m_ill = 1'b0;
    m_be  = 1'b0;
    for (int i = 0; i < n; i++) begin
      c = blank(OpImm, 1'b0); c.rst_n = 1'b0; c.o.state = 3'd0; push(c);
    end
  endtask

  task automatic gen_fetch_timeout();
    cyc_t c;
    for (int i = 0; i <= int'(Timeout); i++) begin
      c = blank(OpImm, 1'b0); c.o.state = 3'd0; c.o.mem_req = 1'b1; push(c);
    end
    m_be = 1'b1;
  endtask

  // Plays the queued cycles, compares each, then checks latency to the first retire
  // (0 = no retire expected, negative = skip the latency check).
  task automatic run(input string name, input int exp_lat);
    cyc_t c;
    out_t act;
    int first, idx, lat;
    first = -1;
    idx   = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      rst_n         = c.rst_n;
      bus.mem_ready = c.mem_ready;
      bus.br_cond   = c.br_cond;
      bus.opcode    = c.opcode;
      bus.funct3    = 3'b000;
      #2;
      act.state         = bus.state;
      act.mem_req       = bus.mem_req;
      act.mem_we        = bus.mem_we;
      act.mem_addr_sel  = bus.mem_addr_sel;
      act.ir_we         = bus.ir_we;
      act.pc_we         = bus.pc_we;
      act.pc_sel        = bus.pc_sel;
      act.alu_a_sel     = bus.alu_a_sel;
      act.alu_b_sel     = bus.alu_b_sel;
      act.alu_op        = bus.alu_op;
      act.rf_we         = bus.rf_we;
      act.wb_sel        = bus.wb_sel;
      act.instr_retired = bus.instr_retired;
      act.illegal       = bus.illegal;
      act.bus_err       = bus.bus_err;
      checks++;
      if (act !== c.o) begin
        errors++;
        $display("FAIL %s cycle %0d: got state=%0d outs=%05h, expected state=%0d outs=%05h",
                 name, idx, act.state, act, c.o.state, c.o);
      end
      if (act.instr_retired === 1'b1 && first < 0) first = idx;
      idx++;
    end
    if (exp_lat >= 0) begin
      lat = (first < 0) ? 0 : first + 1;
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL %s latency: got %0d, expected %0d", name, lat, exp_lat);
      end
    end
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    bus.br_cond   = 1'b0;
    bus.opcode    = OpImm;
    bus.funct3    = 3'b000;

    gen_reset(2);                        run("reset", -1);
    gen_instr(OpImm, 0, 0, 0, 0);        run("addi", 4);
    gen_instr(OpLoad, 0, 0, 3, 0);       run("lw_wait3", 8);
    gen_instr(OpLoad, 0, 0, 0, 0);       run("lw", 5);
    gen_instr(OpBranch, 1, 0, 0, 0);     run("beq_taken", 3);
    gen_instr(OpBranch, 0, 0, 0, 0);     run("beq_not_taken", 3);
    gen_instr(OpJalr, 0, 0, 0, 0);       run("jalr", 4);
    gen_instr(OpJal, 0, 0, 0, 0);        run("jal", 4);
    gen_instr(OpStore, 0, 0, 0, 0);      run("sw", 4);
    gen_instr(OpStore, 0, 0, 1, 0);      run("sw_wait1", 5);
    gen_instr(OpR, 0, 0, 0, 0);          run("add", 4);
    gen_instr(OpLui, 0, 0, 0, 0);        run("lui", 4);
    gen_instr(OpAuipc, 0, 0, 0, 0);      run("auipc", 4);

    gen_instr(7'b0000000, 0, 0, 0, 0);
    gen_trap(20);                        run("illegal", 0);
    gen_reset(2);                        run("reset_after_illegal", -1);
    gen_instr(OpImm, 0, 0, 0, 0);        run("addi_after_illegal", 4);

    gen_fetch_timeout();
    gen_trap(5);                         run("fetch_timeout", 0);
    gen_reset(2);                        run("reset_after_timeout", -1);
    gen_instr(OpImm, 0, 4, 0, 0);        run("fetch_ready_at_limit", 8);

    gen_instr(OpLoad, 0, 0, 2, 1);
    gen_reset(1);                        run("reset_mid_mem", 0);
    gen_instr(OpImm, 0, 0, 0, 0);        run("addi_after_abort", 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
